// File: rtl/imm2instr_pkg.sv
// imm2instr_pkg: extop encodings, opcode constants and the immediate scatter function
package imm2instr_pkg;
  typedef enum logic [2:0] {EXT_I = 3'd0, EXT_U = 3'd1, EXT_S = 3'd2, EXT_B = 3'd3, EXT_J = 3'd4} extop_t;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  function automatic logic [31:0] pack_imm(input logic [31:0] base, input logic [31:0] imm, input logic [2:0] ext);
    logic [31:0] r;
    r = base;
    case (ext)
      EXT_I: r = {imm[11:0], base[19:0]};
      EXT_U: r = {imm[31:12], base[11:0]};
      EXT_S: r = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      EXT_B: r = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      EXT_J: r = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
      default: r = base;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/imm2instr_range_chk.sv
// imm_range_chk: flags immediates that the selected format cannot represent, and illegal extops
module imm_range_chk
  import imm2instr_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  extop,
  output logic        err
);
  logic s11, s12, s20;
  assign s11 = &imm[31:11] | ~|imm[31:11];
  assign s12 = &imm[31:12] | ~|imm[31:12];
  assign s20 = &imm[31:20] | ~|imm[31:20];
  always_comb
    err = (extop == EXT_I || extop == EXT_S) ? !s11 :
          (extop == EXT_U) ? |imm[11:0] :
          (extop == EXT_B) ? (!s12 || imm[0]) :
          (extop == EXT_J) ? (!s20 || imm[0]) : 1'b1;
endmodule

// File: rtl/imm2instr.sv
// imm2instr: two-stage valid/ready immediate packer with range check and saturating error count
module imm2instr
  import imm2instr_pkg::*;
#(
  parameter int ERR_CNT_W = 16,
  parameter bit DROP_ERR  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_base,
  input  logic [31:0]          in_imm,
  input  logic [2:0]           in_extop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  logic        s1_valid, s1_err, chk_err, s1_load, s2_load, drop;
  logic [31:0] s1_instr;
  imm_range_chk u_chk (.imm(in_imm), .extop(in_extop), .err(chk_err));
  // a droppable error entry frees S1 even while S2 is stalled
  assign drop     = DROP_ERR && s1_err;
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load || drop;
  assign in_ready = s1_load;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_err    <= 1'b0;
      s1_instr  <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_instr <= chk_err ? in_base : pack_imm(in_base, in_imm, in_extop);
          s1_err   <= chk_err;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid && !drop;
        if (s1_valid && !drop) begin
          out_instr <= s1_instr;
          out_err   <= s1_err;
        end
      end
      if (in_valid && s1_load && chk_err && !(&err_cnt))
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
endmodule
